z380_waitgen_loader: RTL and testbench
======================================

// Module: z380_waitgen_loader
// PURPOSE
//   CSR initiator that programs wait-state profile registers over csr_if.
//   On start, writes PROFILE_COUNT profile values to CSR_BASE + 4*i, one transaction at a time.
//   Sits beside the boot/reset sequencer, so the bus-cycle wait profiles are valid before the CPU leaves reset.
// PARAMETERS
//   PROFILE_COUNT  8             number of profile registers to program (>=1)
//   COUNT_W        8             bits per profile value (<=32)
//   INDEX_W        clog2(PC),>=1 width of profile index / err_index
//   CSR_BASE       32'h00a22000  address of profile 0; profile i is at CSR_BASE + 4*i
// PORTS
//   clk        in   1                    clock
//   rst        in   1                    synchronous, active-high reset
//   start      in   1                    begin load; accepted only while idle
//   cfg_waits  in   PROFILE_COUNT*COUNT_W  profile values, profile i = bits [i*COUNT_W +: COUNT_W]
//   busy       out  1                    load in progress
//   done       out  1                    sticky: last load completed without fault
//   error      out  1                    sticky: last load aborted (fault or verify mismatch)
//   err_index  out  INDEX_W              profile index at which the abort occurred
//   csr        csr_if.master             req_valid/ready/write/addr/wdata/wstrb; rsp_valid/ready/rdata/fault/side_effect
// BEHAVIOUR
//   - One clock (clk); reset rst is synchronous and active-high.
//   - Reset values: busy=0, done=0, error=0, err_index=0, req_valid=0, req_write=0, req_addr=0, req_wdata=0,
//     req_wstrb=0, rsp_ready=1; FSM in IDLE; index=0.
//   - FSM states: IDLE, WR_REQ, WR_RSP, [RD_REQ, RD_RSP], FIN.
//   - IDLE:
//     - start=1 latches cfg_waits into a shadow register, clears done/error/err_index, sets index=0 and busy=1,
//       and moves to WR_REQ.
//     - start while busy is ignored; the shadow copy is not updated mid-load.
//   - WR_REQ:
//     - Drives req_valid=1, req_write=1, req_addr=CSR_BASE + 32'(index*4),
//       req_wdata = zero-extended shadow[index], req_wstrb=4'hF.
//     - All request fields are held stable until req_valid && req_ready, then the FSM moves to WR_RSP.
//     - req_valid drops in the cycle after the fire.
//   - WR_RSP:
//     - Waits for rsp_valid; rsp_ready=1 at all times, so a response is consumed the cycle it is valid.
//     - rsp_fault=1: error=1, err_index=index, go to FIN.
//     - No fault: go to RD_REQ (VERIFY) or advance.
//   - Advance:
//     - index==PROFILE_COUNT-1: go to FIN with done=1.
//     - Otherwise index+1 and back to WR_REQ. index never wraps past PROFILE_COUNT-1.
//   - FIN: busy=0, then IDLE in the next cycle; done and error hold until the next accepted start or rst.
//   - At most one outstanding transaction; no new request is issued before the previous response is consumed.
//   - rsp_side_effect is ignored.
//   - rsp_valid while not in *_RSP (e.g. a stray response after a reset mid-load) is drained (rsp_ready=1) and ignored.
//   - rst mid-load: all outputs return to their reset values on the next edge; the partial programming is not undone.
//   - Latency, zero-wait responder (req_ready=1; rsp one cycle after fire), measured from the start cycle:
//     - done rises 2*PROFILE_COUNT+1 cycles later without VERIFY.
//     - done rises 4*PROFILE_COUNT+1 cycles later with VERIFY.
// CONFIGURATION
//   Z380_WAITGEN_LOADER_VERIFY_EN
//     defined:
//       - After each successful write, RD_REQ issues a read (req_write=0, same addr, req_wstrb=0).
//       - RD_RSP checks the response:
//         - rsp_fault=1, or rsp_rdata[COUNT_W-1:0] != shadow[index]: error=1, err_index=index, FIN.
//         - Otherwise advance.
//       - rsp_rdata bits above COUNT_W are ignored.
//     undefined:
//       - RD_* states are absent; write-only load, and rsp_rdata is unused.
// TESTING
//   1. Reset, PROFILE_COUNT=8, cfg_waits profile i = i+1, zero-wait responder, start pulse:
//      -> 8 writes in order to addr 0x00a22000..0x00a2201C with data 1..8, wstrb F;
//         done=1 at start+17 (start+33 with VERIFY); error=0; busy=0.
//   2. Same load with req_ready held low 3 cycles on each request:
//      -> addr/wdata/write stable while stalled; exactly 8 fires; done=1.
//   3. Responder returns rsp_fault on profile 5:
//      -> no request issued for profile 6; error=1, err_index=5, done=0.
//   4. start re-pulsed mid-load and cfg_waits changed mid-load:
//      -> ignored; written data still equals the values latched at the first start.
//   5. rst asserted while in WR_RSP at profile 3, then stray rsp_valid:
//      -> all outputs at reset values; stray response consumed; no new request until start.
//   6. VERIFY_EN, responder returns readback 0x07 for profile 2 (expected 0x03):
//      -> error=1, err_index=2; no write to profile 3.

Source files
------------

// File: rtl/z380_waitgen_loader.sv
// rtl/z380_waitgen_loader.sv - CSR initiator that programs the wait-state profile registers
//
// On start, copies cfg_waits into a shadow register and writes profile i to
// CSR_BASE + 4*i, one transaction at a time, until every profile is written
// or a response faults.
// Optional feature macro: Z380_WAITGEN_LOADER_VERIFY_EN reads back each
// profile after its write and aborts on a fault or a data mismatch.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             begin a load (accepted only while idle)
//   cfg_waits         packed profile values, profile i = [i*COUNT_W +: COUNT_W]
//   busy              load in progress
//   done / error      sticky outcome of the last load
//   err_index         profile index at which the load aborted
//   req_*             CSR request channel (valid/ready, write, addr, wdata, wstrb)
//   rsp_*             CSR response channel (valid/ready, rdata, fault, side_effect)
module z380_waitgen_loader #(
    parameter int          PROFILE_COUNT = 8,
    parameter int          COUNT_W       = 8,
    parameter int          INDEX_W       = (PROFILE_COUNT > 1) ? $clog2(PROFILE_COUNT) : 1,
    parameter logic [31:0] CSR_BASE      = 32'h00a22000
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [PROFILE_COUNT*COUNT_W-1:0] cfg_waits,
    output logic                             busy,
    output logic                             done,
    output logic                             error,
    output logic [INDEX_W-1:0]               err_index,
    output logic                             req_valid,
    input  logic                             req_ready,
    output logic                             req_write,
    output logic [31:0]                      req_addr,
    output logic [31:0]                      req_wdata,
    output logic [3:0]                       req_wstrb,
    input  logic                             rsp_valid,
    output logic                             rsp_ready,
    input  logic [31:0]                      rsp_rdata,
    input  logic                             rsp_fault,
    input  logic                             rsp_side_effect
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WR_REQ = 3'd1;
    localparam logic [2:0] S_WR_RSP = 3'd2;
`ifdef Z380_WAITGEN_LOADER_VERIFY_EN
    localparam logic [2:0] S_RD_REQ = 3'd3;
    localparam logic [2:0] S_RD_RSP = 3'd4;
`endif
    localparam logic [2:0] S_FIN    = 3'd5;

    localparam logic [INDEX_W-1:0] LAST_INDEX = INDEX_W'(PROFILE_COUNT - 1);

    logic [2:0]                       state;
    logic [INDEX_W-1:0]               index;
    logic [INDEX_W-1:0]               next_index;
    logic [PROFILE_COUNT*COUNT_W-1:0] shadow;
    logic [COUNT_W-1:0]               cur_val;
    logic [COUNT_W-1:0]               next_val;
    logic                             step_ok;

    // Responses are always accepted; stray responses outside *_RSP are drained.
    assign rsp_ready = 1'b1;

    // Side-effect flag and (in write-only builds) read data carry no meaning here.
    logic unused_rsp;
    assign unused_rsp = ^{rsp_side_effect, rsp_rdata};

    function automatic logic [31:0] profile_addr(input logic [INDEX_W-1:0] idx);
        logic [31:0] off;
        off = '0;
        off[INDEX_W-1:0] = idx;
        return CSR_BASE + (off << 2);
    endfunction

    function automatic logic [31:0] zext(input logic [COUNT_W-1:0] v);
        logic [31:0] r;
        r = '0;
        r[COUNT_W-1:0] = v;
        return r;
    endfunction

    assign next_index = index + INDEX_W'(1);
    assign cur_val    = shadow[int'(index) * COUNT_W +: COUNT_W];
    // Only consumed when index is not the last profile, so it never reads past the shadow.
    assign next_val   = shadow[int'(next_index) * COUNT_W +: COUNT_W];

    // step_ok marks the response that completes the current profile successfully.
    always_comb begin
        step_ok = 1'b0;
`ifdef Z380_WAITGEN_LOADER_VERIFY_EN
        if (state == S_RD_RSP && rsp_valid && !rsp_fault && rsp_rdata[COUNT_W-1:0] == cur_val)
            step_ok = 1'b1;
`else
        if (state == S_WR_RSP && rsp_valid && !rsp_fault)
            step_ok = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            index     <= '0;
            shadow    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            err_index <= '0;
            req_valid <= 1'b0;
            req_write <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            req_wstrb <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        // Profile 0 comes straight from cfg_waits: shadow is only loaded this edge.
                        shadow    <= cfg_waits;
                        done      <= 1'b0;
                        error     <= 1'b0;
                        err_index <= '0;
                        index     <= '0;
                        busy      <= 1'b1;
                        req_valid <= 1'b1;
                        req_write <= 1'b1;
                        req_addr  <= CSR_BASE;
                        req_wdata <= zext(cfg_waits[COUNT_W-1:0]);
                        req_wstrb <= 4'hF;
                        state     <= S_WR_REQ;
                    end
                end
                S_WR_REQ: begin
                    if (req_ready) begin
                        req_valid <= 1'b0;
                        state     <= S_WR_RSP;
                    end
                end
                S_WR_RSP: begin
                    if (rsp_valid) begin
                        if (rsp_fault) begin
                            error     <= 1'b1;
                            err_index <= index;
                            state     <= S_FIN;
                        end
`ifdef Z380_WAITGEN_LOADER_VERIFY_EN
                        else begin
                            // Read back from the same address just written.
                            req_valid <= 1'b1;
                            req_write <= 1'b0;
                            req_wstrb <= 4'h0;
                            state     <= S_RD_REQ;
                        end
`endif
                    end
                end
`ifdef Z380_WAITGEN_LOADER_VERIFY_EN
                S_RD_REQ: begin
                    if (req_ready) begin
                        req_valid <= 1'b0;
                        state     <= S_RD_RSP;
                    end
                end
                S_RD_RSP: begin
                    if (rsp_valid && !step_ok) begin
                        error     <= 1'b1;
                        err_index <= index;
                        state     <= S_FIN;
                    end
                end
`endif
                S_FIN: begin
                    busy  <= 1'b0;
                    done  <= ~error;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            // Advance to the next profile (or finish) after a clean response.
            if (step_ok) begin
                if (index == LAST_INDEX) begin
                    state <= S_FIN;
                end else begin
                    index     <= next_index;
                    req_valid <= 1'b1;
                    req_write <= 1'b1;
                    req_addr  <= profile_addr(next_index);
                    req_wdata <= zext(next_val);
                    req_wstrb <= 4'hF;
                    state     <= S_WR_REQ;
                end
            end
        end
    end

endmodule

// File: tb/tb_z380_waitgen_loader.sv
// tb/tb_z380_waitgen_loader.sv - self-checking bench for z380_waitgen_loader
module tb_z380_waitgen_loader;

    localparam int          PC   = 8;
    localparam int          CW   = 8;
    localparam int          IW   = 3;
    localparam logic [31:0] BASE = 32'h00a22000;
`ifdef Z380_WAITGEN_LOADER_VERIFY_EN
    localparam int NPP = 2;
`else
    localparam int NPP = 1;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [PC*CW-1:0]  cfg_waits = '0;
    logic              busy, done, error;
    logic [IW-1:0]     err_index;
    logic              req_valid, req_write;
    logic              req_ready = 1'b0;
    logic [31:0]       req_addr, req_wdata;
    logic [3:0]        req_wstrb;
    logic              rsp_valid = 1'b0;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata = '0;
    logic              rsp_fault = 1'b0;
    logic              rsp_side_effect = 1'b0;

    z380_waitgen_loader #(.PROFILE_COUNT(PC), .COUNT_W(CW), .INDEX_W(IW), .CSR_BASE(BASE)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_waits(cfg_waits),
        .busy(busy), .done(done), .error(error), .err_index(err_index),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_fault(rsp_fault), .rsp_side_effect(rsp_side_effect)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t exp_q[$];
    txn_t act_log[$];
    int   checks = 0;
    int   failures = 0;

    logic [CW-1:0] mem [PC];
    int stall_n = 0, fault_idx = -1, bad_idx = -1, hold_idx = -1, stray_req = 0;
    int done_cyc = -1, start_cyc = 0;
    bit exp_err;
    int exp_idx;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Responder plus per-cycle compare process.
    initial begin : responder
        bit          pend = 0, pend_fault = 0, stalled = 0, done_prev = 0;
        logic [31:0] pend_rdata = '0;
        int          scnt = 0, stray_done = 0, k;
        txn_t        held, e;
        logic [3:0]  held_strb = '0;
        forever begin
            @(negedge clk);
            rsp_valid = 1'b0;
            rsp_fault = 1'b0;
            rsp_rdata = $urandom;
            chk("rsp_ready_high", rsp_ready, 1);
            if (done && !done_prev) done_cyc = cyc;
            done_prev = done;
            if (rst) begin
                pend = 0; stalled = 0; scnt = 0; req_ready = 1'b0;
            end else begin
                if (pend) begin
                    rsp_valid = 1'b1; rsp_fault = pend_fault; rsp_rdata = pend_rdata; pend = 0;
                end else if (stray_req != stray_done) begin
                    stray_done = stray_req;
                    rsp_valid = 1'b1;
                    rsp_fault = 1'($urandom_range(0, 1));
                end
                if (req_valid) begin
                    chk("busy_during_req", busy, 1);
                    if (stalled) begin
                        chk("stall_addr", req_addr, held.addr);
                        chk("stall_wdata", req_wdata, held.data);
                        chk("stall_write", req_write, held.wr);
                        chk("stall_wstrb", req_wstrb, held_strb);
                    end
                    held = '{req_write, req_addr, req_wdata};
                    held_strb = req_wstrb;
                    if (scnt < stall_n) begin
                        req_ready = 1'b0; scnt++; stalled = 1;
                    end else begin
                        req_ready = 1'b1; scnt = 0; stalled = 0;
                        act_log.push_back(held);
                        if (exp_q.size() == 0) begin
                            checks++; failures++;
                            $display("FAIL extra_request: got addr %h write %0d, expected none", req_addr, req_write);
                        end else begin
                            e = exp_q.pop_front();
                            chk("req_write", req_write, e.wr);
                            chk("req_addr", req_addr, e.addr);
                            if (e.wr) begin
                                chk("req_wdata", req_wdata, e.data);
                                chk("req_wstrb", req_wstrb, 4'hF);
                            end else begin
                                chk("rd_wstrb", req_wstrb, 4'h0);
                            end
                        end
                        k = int'((req_addr - BASE) >> 2);
                        pend_fault = 0;
                        pend_rdata = $urandom;
                        if (k >= 0 && k < PC) begin
                            if (req_write) begin
                                mem[k] = req_wdata[CW-1:0];
                                pend_fault = (k == fault_idx);
                            end else begin
                                pend_rdata[CW-1:0] = (k == bad_idx) ? (mem[k] ^ 8'h04) : mem[k];
                            end
                        end
                        pend = !(req_write && k == hold_idx);
                    end
                end else begin
                    req_ready = 1'b0; stalled = 0;
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string t);
        chk({t, "_busy"}, busy, 0);
        chk({t, "_done"}, done, 0);
        chk({t, "_error"}, error, 0);
        chk({t, "_err_index"}, err_index, 0);
        chk({t, "_req_valid"}, req_valid, 0);
        chk({t, "_req_write"}, req_write, 0);
        chk({t, "_req_addr"}, req_addr, 0);
        chk({t, "_req_wdata"}, req_wdata, 0);
        chk({t, "_req_wstrb"}, req_wstrb, 0);
        chk({t, "_rsp_ready"}, rsp_ready, 1);
    endtask

    // Builds the expected transaction list from the load rules, then pulses start.
    task automatic begin_load(input logic [PC*CW-1:0] cfg, input int stall, input int fault, input int bad);
        logic [31:0] d;
        stall_n = stall; fault_idx = fault; bad_idx = bad;
        exp_err = 0; exp_idx = 0;
        for (int k = 0; k < PC; k++) begin
            d = '0;
            d[CW-1:0] = cfg[k*CW +: CW];
            exp_q.push_back('{1'b1, BASE + 32'(4 * k), d});
            if (fault == k) begin exp_err = 1; exp_idx = k; break; end
            if (NPP == 2) begin
                exp_q.push_back('{1'b0, BASE + 32'(4 * k), d});
                if (bad == k) begin exp_err = 1; exp_idx = k; break; end
            end
        end
        cfg_waits = cfg;
        start = 1'b1;
        tick();
        start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic finish_load(input string t, input bit chk_lat);
        int n = 0;
        while (busy && n < 3000) begin tick(); n++; end
        if (busy) begin
            checks++; failures++;
            $display("FAIL %s_timeout: got busy=1 expected busy=0 within 3000 cycles", t);
        end
        tick();
        chk({t, "_busy"}, busy, 0);
        chk({t, "_done"}, done, !exp_err);
        chk({t, "_error"}, error, exp_err);
        chk({t, "_err_index"}, err_index, exp_idx);
        chk({t, "_fires_missing"}, exp_q.size(), 0);
        if (chk_lat && !exp_err)
            chk({t, "_done_latency"}, done_cyc - start_cyc, 2 * NPP * PC + 1);
        exp_q.delete();
        stall_n = 0; fault_idx = -1; bad_idx = -1;
    endtask

    logic [PC*CW-1:0] seq_cfg;
    int               base;

    initial begin : main
        int f, b, s;
        for (int i = 0; i < PC; i++) seq_cfg[i*CW +: CW] = CW'(i + 1);
        tick(3);
        chk_reset_vals("reset");
        rst = 1'b0;
        tick(2);

        // 1: ordered writes, zero-wait, latency
        base = act_log.size();
        begin_load(seq_cfg, 0, -1, -1);
        finish_load("t1", 1);
        chk("t1_first_addr", act_log[base].addr, 32'h00a22000);
        chk("t1_first_data", act_log[base].data, 32'h1);
        chk("t1_last_addr", act_log[base + (PC - 1) * NPP].addr, 32'h00a2201C);
        chk("t1_last_data", act_log[base + (PC - 1) * NPP].data, 32'h8);

        // 2: req_ready stalled 3 cycles per request
        base = act_log.size();
        begin_load(seq_cfg, 3, -1, -1);
        finish_load("t2", 0);
        chk("t2_fire_count", act_log.size() - base, PC * NPP);

        // 3: fault on profile 5
        base = act_log.size();
        begin_load(seq_cfg, 0, 5, -1);
        finish_load("t3", 0);
        chk("t3_last_addr", act_log[act_log.size() - 1].addr, 32'h00a22014);
        chk("t3_err_index", err_index, 5);

        // 4: start re-pulsed and cfg changed mid-load
        begin_load({$urandom, $urandom}, 1, -1, -1);
        tick(5);
        cfg_waits = {$urandom, $urandom};
        start = 1'b1;
        tick();
        start = 1'b0;
        finish_load("t4", 0);

        // 5: reset while waiting in WR_RSP at profile 3, then a stray response
        base = act_log.size();
        hold_idx = 3;
        begin_load(seq_cfg, 0, -1, -1);
        s = 0;
        while (act_log.size() - base < 3 * NPP + 1 && s < 500) begin tick(); s++; end
        tick(3);
        chk("t5_busy_before_rst", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_vals("t5");
        chk("t5_fires", act_log.size() - base, 3 * NPP + 1);
        exp_q.delete();
        hold_idx = -1;
        stray_req++;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t5_no_req", req_valid, 0);
            chk("t5_idle", busy, 0);
        end

`ifdef Z380_WAITGEN_LOADER_VERIFY_EN
        // 6: readback 0x07 for profile 2
        begin_load(seq_cfg, 0, -1, 2);
        finish_load("t6", 0);
        chk("t6_last_addr", act_log[act_log.size() - 1].addr, 32'h00a22008);
        chk("t6_err_index", err_index, 2);
`endif

        // Randomized loads
        for (int r = 0; r < 12; r++) begin
            f = -1; b = -1;
            s = $urandom_range(0, 2);
            case ($urandom_range(0, 2))
                0: f = $urandom_range(0, PC - 1);
                1: b = $urandom_range(0, PC - 1);
                default: ;
            endcase
            begin_load({$urandom, $urandom}, s, f, b);
            finish_load("rand", s == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
